amo_unit: RTL and testbench
===========================

// Module: amo_unit
// PURPOSE
//  Memory-stage sequencer for RV64A: LR.W/D, SC.W/D and AMO{SWAP,ADD,AND,OR,XOR,MAX,MIN,MAXU,MINU}.W/D.
//  Drives the reservation block's LR/SC strobes (ctl.lrw/ctl.sc path) and consumes its reservation_set result.
//  Runs read-modify-write over the data-bus handshake. Returns the rd value to writeback.
//  Holds the pipeline (busy) for the whole access.
// PARAMETERS
//  XLEN       64  datapath width; only 64 is supported
//  OP_W        4  width of op encoding (0 LR, 1 SC, 2 SWAP, 3 ADD, 4 AND, 5 OR, 6 XOR, 7 MAX, 8 MIN, 9 MAXU, 10 MINU)
// PORTS
//  clk         in   1     rising-edge clock
//  reset       in   1     asynchronous, active-low reset
//  start       in   1     accept op/addr/src/is_word (sampled in IDLE only)
//  op          in   OP_W  atomic op code
//  is_word     in   1     1 = .W (32-bit, sign-extended result), 0 = .D
//  addr        in   64    effective address
//  src         in   64    rs2 value
//  flush       in   1     pipeline flush (sync)
//  busy        out  1     high in every state except IDLE
//  done        out  1     1-cycle pulse, result valid
//  result      out  64    rd value
//  misalign    out  1     qualifies done: address fault, no memory access made
//  resv_lr     out  1     1-cycle pulse: LR completed at resv_addr
//  resv_sc     out  1     SC check strobe at resv_addr (combinational reservation_set returns same cycle)
//  resv_addr   out  64    registered op address
//  reservation_set in 1   SC success from reservation block
//  mem_req     out  1     bus request
//  mem_we      out  1     1 write, 0 read
//  mem_addr    out  64    {addr[63:3],3'b0}
//  mem_wdata   out  64    store data (word value replicated to both halves)
//  mem_strb    out  8     byte enables: .D 8'hFF; .W 8'h0F (addr[2]=0) / 8'hF0 (addr[2]=1)
//  mem_ready   in   1     bus completes current request this cycle
//  mem_rdata   in   64    read data, valid with mem_ready on reads
// BEHAVIOUR
//  Reset: state IDLE; busy, done, misalign, resv_lr, resv_sc, mem_req, mem_we = 0; result, mem_* buses = 0.
//  FSM states: IDLE, CHECK, READ, WRITE, RESP.
//   IDLE  start: register inputs. If misaligned (.W addr[1:0]!=0, .D addr[2:0]!=0) -> RESP (misalign=1).
//         Otherwise: SC -> CHECK; all other ops -> READ.
//   CHECK resv_sc=1 for exactly this cycle.
//         If reservation_set=1: result=0 -> WRITE (mem_wdata=src).
//         If reservation_set=0: result=1 -> RESP (no bus access).
//   READ  mem_req=1, mem_we=0. On mem_ready, capture old = selected half (sign-extended if .W).
//         LR: result=old, resv_lr pulse -> RESP.
//         AMO: result=old, compute new -> WRITE.
//   WRITE mem_req=1, mem_we=1 -> RESP on mem_ready.
//   RESP  done=1 for one cycle -> IDLE. Minimum latency start->done: SC fail 2 cycles; LR 3 cycles; AMO/SC ok 4 cycles.
//  Handshake: mem_req/mem_we/mem_addr/mem_wdata/mem_strb stable from request until the cycle mem_ready=1.
//   mem_ready while mem_req=0 is ignored. Back-to-back: mem_req drops for >=1 cycle between READ and WRITE.
//  Arithmetic: .W ops use 32-bit operands src[31:0] and old[31:0]; signed MAX/MIN compare as 32-bit signed.
//   ADD wraps modulo 2^32 (.W) or 2^64 (.D). Result sign-extends bit 31 for .W.
//  start while busy: ignored, no effect.
//  flush: in READ (or CHECK) abandons the op. Go to IDLE next cycle, no done, no resv_lr.
//   An outstanding read is dropped: the bus must accept deassertion.
//   In WRITE the store completes (atomicity), then IDLE with done suppressed. In RESP, done is suppressed.
//  reset asserted mid-operation: immediate return to IDLE, mem_req falls asynchronously.
// TESTING
//  AMOADD.D addr=0x1000, mem=5, src=3, 1-cycle ready -> read then write 8, strb FF, result=5, done at cycle 4.
//  AMOMAX.W addr=0x1004, mem upper=0xFFFFFFFF, src=1 -> strb F0, wdata=0x00000001_00000001, result=0xFFFF_FFFF_FFFF_FFFF.
//  LR.D 0x2000 then SC.D 0x2000 with reservation_set=1 -> resv_lr pulse, SC writes, result=0.
//  SC.W with reservation_set=0 -> no mem_req ever, result=1, done 2 cycles after start.
//  AMOSWAP.W addr=0x1002 -> misalign=1 with done, mem_req never asserted.
//  mem_ready delayed 5 cycles; flush during READ -> outputs stable while waiting, no done.
//   flush during WRITE -> write completes, done never pulses.

Source files
------------

// File: rtl/amo_unit_if.sv
// ============================================================================
//  amo_unit_if : data-bus handshake between the atomic sequencer and memory
//  Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface amo_unit_if #(
    parameter int XLEN = 64
);
    logic                mem_req;
    logic                mem_we;
    logic [XLEN-1:0]     mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN/8-1:0]   mem_strb;
    logic                mem_ready;
    logic [XLEN-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_strb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_strb,
        output mem_ready, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/amo_unit.sv
// ============================================================================
//  amo_unit : RV64A memory-stage sequencer (LR/SC and AMO read-modify-write)
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module amo_unit #(
    parameter int XLEN = 64,
    parameter int OP_W = 4
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             start_i,
    input  wire logic [OP_W-1:0]  op_i,
    input  wire logic             is_word_i,
    input  wire logic [XLEN-1:0]  addr_i,
    input  wire logic [XLEN-1:0]  src_i,
    input  wire logic             flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [XLEN-1:0]       result_o,
    output logic                  misalign_o,
    output logic                  resv_lr_o,
    output logic                  resv_sc_o,
    output logic [XLEN-1:0]       resv_addr_o,
    input  wire logic             reservation_set_i,
    amo_unit_if.master            mem_bus
);

    localparam logic [OP_W-1:0] OP_LR   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SC   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SWAP = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_MAX  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_MIN  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_MAXU = OP_W'(9);
    localparam logic [OP_W-1:0] OP_MINU = OP_W'(10);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            state_q,     state_d;
    logic [OP_W-1:0]   op_q,        op_d;
    logic              word_q,      word_d;
    logic [XLEN-1:0]   addr_q,      addr_d;
    logic [XLEN-1:0]   src_q,       src_d;
    logic [XLEN-1:0]   result_q,    result_d;
    logic              misalign_q,  misalign_d;
    logic              lr_pend_q,   lr_pend_d;
    logic              suppress_q,  suppress_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [XLEN-1:0]   mem_addr_q,  mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [7:0]        mem_strb_q,  mem_strb_d;

    logic [31:0]       rd_half;
    logic [XLEN-1:0]   old_val;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   amo_wdata;
    logic [XLEN-1:0]   sc_wdata;
    logic              lt_s;
    logic              lt_u;
    logic              start_mis;

    // Operands are sign-extended for .W so one 64-bit signed compare serves both widths
    always_comb begin
        rd_half   = addr_q[2] ? mem_bus.mem_rdata[63:32] : mem_bus.mem_rdata[31:0];
        old_val   = word_q ? {{32{rd_half[31]}}, rd_half} : mem_bus.mem_rdata;
        opb       = word_q ? {{32{src_q[31]}}, src_q[31:0]} : src_q;
        lt_s      = $signed(old_val) < $signed(opb);
        lt_u      = word_q ? (old_val[31:0] < opb[31:0]) : (old_val < opb);
        alu       = old_val;
        unique case (op_q)
            OP_SWAP: alu = opb;
            OP_ADD:  alu = old_val + opb;
            OP_AND:  alu = old_val & opb;
            OP_OR:   alu = old_val | opb;
            OP_XOR:  alu = old_val ^ opb;
            OP_MAX:  alu = lt_s ? opb : old_val;
            OP_MIN:  alu = lt_s ? old_val : opb;
            OP_MAXU: alu = lt_u ? opb : old_val;
            OP_MINU: alu = lt_u ? old_val : opb;
            default: alu = old_val;
        endcase
        amo_wdata = word_q ? {alu[31:0], alu[31:0]} : alu;
        sc_wdata  = word_q ? {src_q[31:0], src_q[31:0]} : src_q;
        start_mis = is_word_i ? (addr_i[1:0] != 2'b00) : (addr_i[2:0] != 3'b000);
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        word_d      = word_q;
        addr_d      = addr_q;
        src_d       = src_q;
        result_d    = result_q;
        misalign_d  = misalign_q;
        lr_pend_d   = lr_pend_q;
        suppress_d  = suppress_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_strb_d  = mem_strb_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d       = op_i;
                    word_d     = is_word_i;
                    addr_d     = addr_i;
                    src_d      = src_i;
                    misalign_d = start_mis;
                    lr_pend_d  = 1'b0;
                    suppress_d = 1'b0;
                    if (start_mis) begin
                        result_d = '0;
                        state_d  = S_RESP;
                    end else begin
                        mem_addr_d = {addr_i[XLEN-1:3], 3'b000};
                        mem_strb_d = is_word_i ? (addr_i[2] ? 8'hF0 : 8'h0F) : 8'hFF;
                        if (op_i == OP_SC) begin
                            state_d = S_CHECK;
                        end else begin
                            mem_req_d = 1'b1;
                            mem_we_d  = 1'b0;
                            state_d   = S_READ;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (reservation_set_i) begin
                    result_d    = '0;
                    mem_wdata_d = sc_wdata;
                    mem_we_d    = 1'b1;
                    state_d     = S_WRITE;
                end else begin
                    result_d = XLEN'(1);
                    state_d  = S_RESP;
                end
            end
            S_READ: begin
                if (flush_i) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (mem_bus.mem_ready) begin
                    result_d  = old_val;
                    mem_req_d = 1'b0;
                    if (op_q == OP_LR) begin
                        lr_pend_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        mem_wdata_d = amo_wdata;
                        mem_we_d    = 1'b1;
                        state_d     = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // The store is never abandoned once here; a flush only hides the result
                if (flush_i) begin
                    suppress_d = 1'b1;
                end
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end else if (mem_bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (flush_i) begin
                    suppress_d = 1'b1;
                end
                if (lr_pend_q) begin
                    lr_pend_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            word_q      <= 1'b0;
            addr_q      <= '0;
            src_q       <= '0;
            result_q    <= '0;
            misalign_q  <= 1'b0;
            lr_pend_q   <= 1'b0;
            suppress_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_strb_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            src_q       <= src_d;
            result_q    <= result_d;
            misalign_q  <= misalign_d;
            lr_pend_q   <= lr_pend_d;
            suppress_q  <= suppress_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_strb_q  <= mem_strb_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_RESP) && !lr_pend_q && !suppress_q && !flush_i;
    assign misalign_o  = done_o && misalign_q;
    assign resv_lr_o   = (state_q == S_RESP) && lr_pend_q;
    assign resv_sc_o   = (state_q == S_CHECK) && !flush_i;
    assign resv_addr_o = addr_q;
    assign result_o    = result_q;

    assign mem_bus.mem_req   = mem_req_q;
    assign mem_bus.mem_we    = mem_we_q;
    assign mem_bus.mem_addr  = mem_addr_q;
    assign mem_bus.mem_wdata = mem_wdata_q;
    assign mem_bus.mem_strb  = mem_strb_q;

endmodule

`default_nettype wire

// File: tb/tb_amo_unit.sv
// ============================================================================
//  tb_amo_unit : scoreboard bench for amo_unit with a behavioural memory
//  Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_amo_unit;

    localparam logic [3:0] LR = 4'd0, SC = 4'd1, SWAP = 4'd2, ADD = 4'd3, MAX = 4'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic        is_word = 1'b0;
    logic [63:0] addr = '0;
    logic [63:0] src = '0;
    logic        flush = 1'b0;
    logic        busy, done, misalign, resv_lr, resv_sc, reservation_set;
    logic [63:0] result, resv_addr;

    always #5 clk = ~clk;

    amo_unit_if bus ();

    amo_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .is_word_i(is_word),
        .addr_i(addr), .src_i(src), .flush_i(flush), .busy_o(busy), .done_o(done),
        .result_o(result), .misalign_o(misalign), .resv_lr_o(resv_lr), .resv_sc_o(resv_sc),
        .resv_addr_o(resv_addr), .reservation_set_i(reservation_set), .mem_bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reservation block model, driven purely by the DUT's strobes
    logic        rsv_v = 1'b0;
    logic [63:0] rsv_a = '0;
    assign reservation_set = resv_sc && rsv_v && (resv_addr == rsv_a);
    always @(posedge clk) begin
        if (resv_lr) begin
            rsv_v <= 1'b1;
            rsv_a <= resv_addr;
        end else if (resv_sc) begin
            rsv_v <= 1'b0;
        end
    end

    // Behavioural memory with programmable ready latency
    logic [63:0] mem [logic [63:0]];
    int          mem_delay = 1;
    int          wait_cnt = 0;
    bit          hs = 1'b0;
    logic        we_s;
    logic [63:0] addr_s, wdata_s;
    logic [7:0]  strb_s;
    logic [63:0] last_wdata = '0;
    logic [7:0]  last_strb = '0;
    int          req_cycles = 0;
    bit          req_prev = 1'b0;
    logic [63:0] hold_addr, hold_wdata;
    logic [8:0]  hold_ctl;
    bit          pre_we = 1'b0;
    logic [63:0] pre_key, pre_val;

    always @(negedge clk) begin
        hs = bus.mem_req && bus.mem_ready;
        we_s = bus.mem_we; addr_s = bus.mem_addr; wdata_s = bus.mem_wdata; strb_s = bus.mem_strb;
        if (bus.mem_req) begin
            req_cycles++;
            if (req_prev) begin
                check_val("hold_addr", bus.mem_addr, hold_addr);
                check_val("hold_ctl", {55'd0, bus.mem_we, bus.mem_strb}, {55'd0, hold_ctl});
                check_val("hold_wdata", bus.mem_wdata, hold_wdata);
            end
            hold_addr = bus.mem_addr; hold_wdata = bus.mem_wdata; hold_ctl = {bus.mem_we, bus.mem_strb};
        end
        req_prev = bus.mem_req;
    end

    always @(posedge clk) begin
        #1;
        if (pre_we) mem[pre_key] = pre_val;
        if (!rst_n) begin
            bus.mem_ready = 1'b0; bus.mem_rdata = '0; wait_cnt = 0; hs = 1'b0;
        end else if (hs) begin
            if (we_s) begin
                logic [63:0] w;
                w = mem.exists(addr_s) ? mem[addr_s] : 64'd0;
                for (int b = 0; b < 8; b++) if (strb_s[b]) w[b*8 +: 8] = wdata_s[b*8 +: 8];
                mem[addr_s] = w;
                last_wdata = wdata_s; last_strb = strb_s;
            end
            bus.mem_ready = 1'b0; wait_cnt = 0; hs = 1'b0;
        end else if (bus.mem_req) begin
            wait_cnt++;
            if (wait_cnt >= mem_delay) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 64'd0;
            end
        end else begin
            bus.mem_ready = 1'b0; wait_cnt = 0;
        end
    end

    // Scoreboard
    typedef struct { logic [63:0] res; logic mis; int lat; } exp_t;
    exp_t sb[$];
    int   start_cyc = 0;
    int   n_done = 0;
    int   n_lr = 0;

    always @(negedge clk) begin
        if (resv_lr) n_lr++;
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                check_val("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("result", result, e.res);
                check_val("misalign", {63'd0, misalign}, {63'd0, e.mis});
                if (e.lat >= 0) check_val("latency", 64'(cyc - start_cyc), 64'(e.lat));
            end
        end
    end

    logic [63:0] exp_mem [logic [63:0]];
    bit          pred_v = 1'b0;
    logic [63:0] pred_a = '0;

    function automatic void ref_amo(input logic [3:0] o, input bit w, input logic [63:0] a,
                                    input logic [63:0] m, input logic [63:0] s,
                                    output logic [63:0] rd, output logic [63:0] nm);
        logic [31:0] o32, s32, r32;
        logic [63:0] r64;
        nm = m;
        if (w) begin
            o32 = a[2] ? m[63:32] : m[31:0];
            s32 = s[31:0];
            rd  = {{32{o32[31]}}, o32};
            r32 = o32;
            case (o)
                4'd2:  r32 = s32;
                4'd3:  r32 = o32 + s32;
                4'd4:  r32 = o32 & s32;
                4'd5:  r32 = o32 | s32;
                4'd6:  r32 = o32 ^ s32;
                4'd7:  r32 = ($signed(o32) > $signed(s32)) ? o32 : s32;
                4'd8:  r32 = ($signed(o32) < $signed(s32)) ? o32 : s32;
                4'd9:  r32 = (o32 > s32) ? o32 : s32;
                4'd10: r32 = (o32 < s32) ? o32 : s32;
                default: r32 = o32;
            endcase
            if (a[2]) nm[63:32] = r32; else nm[31:0] = r32;
        end else begin
            rd  = m;
            r64 = m;
            case (o)
                4'd2:  r64 = s;
                4'd3:  r64 = m + s;
                4'd4:  r64 = m & s;
                4'd5:  r64 = m | s;
                4'd6:  r64 = m ^ s;
                4'd7:  r64 = ($signed(m) > $signed(s)) ? m : s;
                4'd8:  r64 = ($signed(m) < $signed(s)) ? m : s;
                4'd9:  r64 = (m > s) ? m : s;
                4'd10: r64 = (m < s) ? m : s;
                default: r64 = m;
            endcase
            nm = r64;
        end
    endfunction

    task automatic set_mem(input logic [63:0] k, input logic [63:0] v);
        @(posedge clk);
        pre_key = k; pre_val = v; pre_we = 1'b1;
        exp_mem[k] = v;
        @(posedge clk);
        #2 pre_we = 1'b0;
    endtask

    task automatic launch(input logic [3:0] o, input bit w, input logic [63:0] a, input logic [63:0] s);
        @(posedge clk);
        #1;
        op = o; is_word = w; addr = a; src = s; start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check_val("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic do_op(input logic [3:0] o, input bit w, input logic [63:0] a,
                         input logic [63:0] s, input int lat, input bit poke);
        exp_t        e;
        logic [63:0] k, m, rd, nm;
        k = {a[63:3], 3'b000};
        m = exp_mem.exists(k) ? exp_mem[k] : 64'd0;
        e.lat = lat;
        e.mis = w ? (a[1:0] != 2'b00) : (a[2:0] != 3'b000);
        if (e.mis) begin
            e.res = '0;
        end else if (o == SC) begin
            if (pred_v && pred_a == a) begin
                e.res = '0;
                nm = m;
                if (!w) nm = s; else if (a[2]) nm[63:32] = s[31:0]; else nm[31:0] = s[31:0];
                exp_mem[k] = nm;
            end else begin
                e.res = 64'd1;
            end
            pred_v = 1'b0;
        end else begin
            ref_amo(o, w, a, m, s, rd, nm);
            e.res = rd;
            exp_mem[k] = nm;
            if (o == LR) begin
                pred_v = 1'b1;
                pred_a = a;
            end
        end
        sb.push_back(e);
        launch(o, w, a, s);
        if (poke) begin
            op = SWAP; addr = a ^ 64'h40; src = ~s; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        int nd, rq;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
        check_val("rst_mem_addr", bus.mem_addr, 64'd0);
        check_val("rst_result", result, 64'd0);
        check_val("rst_strobes", {60'd0, resv_lr, resv_sc, bus.mem_we, misalign}, 64'd0);
        rst_n = 1'b1;

        set_mem(64'h1000, 64'd5);
        do_op(ADD, 1'b0, 64'h1000, 64'd3, 4, 1'b1);
        check_val("add_strb", {56'd0, last_strb}, 64'hFF);
        check_val("add_wdata", last_wdata, 64'd8);
        repeat (2) @(posedge clk);
        #1 check_val("poke_ignored", {63'd0, busy}, 64'd0);

        set_mem(64'h1000, 64'hFFFFFFFF_00000000);
        do_op(MAX, 1'b1, 64'h1004, 64'd1, 4, 1'b0);
        check_val("max_strb", {56'd0, last_strb}, 64'hF0);
        check_val("max_wdata", last_wdata, 64'h00000001_00000001);

        set_mem(64'h2000, 64'h1234_5678_9ABC_DEF0);
        do_op(LR, 1'b0, 64'h2000, 64'd0, 3, 1'b0);
        check_val("lr_pulses", 64'(n_lr), 64'd1);
        do_op(SC, 1'b0, 64'h2000, 64'hABCD, 4, 1'b0);

        rq = req_cycles;
        do_op(SC, 1'b1, 64'h3000, 64'h77, 2, 1'b0);
        check_val("sc_fail_no_req", 64'(req_cycles), 64'(rq));

        rq = req_cycles;
        do_op(SWAP, 1'b1, 64'h1002, 64'h55, 1, 1'b0);
        check_val("misalign_no_req", 64'(req_cycles), 64'(rq));

        set_mem(64'h4000, {$urandom, $urandom});
        set_mem(64'h4008, {$urandom, $urandom});
        for (int i = 0; i < 24; i++) begin
            logic [3:0]  o;
            bit          w;
            logic [63:0] a;
            int          lat;
            o = 4'($urandom_range(0, 10));
            w = 1'($urandom_range(0, 1));
            a = 64'h4000 + 64'(8 * $urandom_range(0, 1)) + (w ? 64'(4 * $urandom_range(0, 1)) : 64'd0);
            mem_delay = $urandom_range(1, 3);
            lat = (mem_delay == 1 && o != SC) ? ((o == LR) ? 3 : 4) : -1;
            do_op(o, w, a, {$urandom, $urandom}, lat, 1'b0);
        end

        // Flush while a slow read is outstanding
        mem_delay = 5;
        set_mem(64'h5000, 64'd77);
        nd = n_done;
        launch(ADD, 1'b0, 64'h5000, 64'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_val("slow_req_held", {62'd0, bus.mem_req, bus.mem_ready}, 64'd2);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check_val("flush_rd_idle", {62'd0, busy, bus.mem_req}, 64'd0);
        repeat (8) @(posedge clk);
        #1 check_val("flush_rd_no_done", 64'(n_done), 64'(nd));

        // Flush during the write phase: store lands, done is hidden
        mem_delay = 1;
        set_mem(64'h5008, 64'd10);
        nd = n_done;
        launch(ADD, 1'b0, 64'h5008, 64'd5);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        exp_mem[64'h5008] = 64'd15;
        check_val("flush_wr_no_done", 64'(n_done), 64'(nd));

        // Reset in the middle of a read
        mem_delay = 5;
        set_mem(64'h5010, 64'd3);
        launch(ADD, 1'b0, 64'h5010, 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_val("async_rst", {62'd0, busy, bus.mem_req}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_delay = 1;
        repeat (4) @(posedge clk);

        check_val("sb_drained", 64'(sb.size()), 64'd0);
        foreach (exp_mem[k]) check_val("mem_final", mem[k], exp_mem[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
